// File: rtl/fetch_unit_pkg.sv
// Shared fetch-unit definitions: next-PC select codes, FSM states, reset PC.
// Imported by the fetch unit and by its next-PC calculator.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_REG    = 2'b10,
    NPC_HOLD   = 2'b11
  } npc_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_e;

  // Word offset from a 24-bit branch immediate, sign-extended to 32 bits.
  function automatic logic [31:0] branch_offset(input logic [23:0] imm);
    return {{6{imm[23]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Next-PC selection: sequential, PC-relative branch, register target or hold.
// Purely combinational; the caller decides when the result is written.
module npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [23:0] imm,
  input  logic [31:0] rm_val,
  input  npc_op_e     npc_op,
  output logic [31:0] npc
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic [31:0] reg_tgt;

  assign pc_plus4   = pc + 32'd4;
  // Branch is relative to the address after the branch instruction.
  assign branch_tgt = pc_plus4 + branch_offset(imm);
  assign reg_tgt    = rm_val & ~32'd3;

  always_comb begin
    npc = pc;
    case (npc_op)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = branch_tgt;
      NPC_REG:    npc = reg_tgt;
      default:    npc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, IR, and a two-state IDLE/WAIT memory handshake.
// A fetch takes one WAIT cycle minimum; WAIT holds with no timeout until im_ack.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IMen,
  input  logic        PCwr,
  input  logic [1:0]  NPCop,
  input  logic [31:0] rm_val,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  input  logic        im_ack,
  output logic [31:0] instruction,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] link,
  output logic        fetch_busy
);

  fetch_state_e state;
  npc_op_e      npc_op;
  logic [31:0]  npc;
  logic         ack_cycle;
  logic         pc_we;

  assign npc_op = npc_op_e'(NPCop);

  npc_calc u_npc_calc (
    .pc     (pc),
    .imm    (instruction[23:0]),
    .rm_val (rm_val),
    .npc    (npc),
    .npc_op (npc_op)
  );

  assign ack_cycle = (state == ST_WAIT) && im_ack;

  // Sequential advance only lands on the completing fetch; jumps only while
  // idle, so im_addr never moves under an outstanding request.
  always_comb begin
    pc_we = 1'b0;
    if (PCwr) begin
      case (npc_op)
        NPC_SEQ:             pc_we = ack_cycle;
        NPC_BRANCH, NPC_REG: pc_we = (state == ST_IDLE);
        default:             pc_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      im_req      <= 1'b0;
      pc          <= RESET_PC;
      instruction <= 32'h0;
      ir_valid    <= 1'b0;
    end else begin
      if (pc_we) pc <= npc;
      case (state)
        ST_IDLE: begin
          if (IMen) begin
            state    <= ST_WAIT;
            im_req   <= 1'b1;
            ir_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (im_ack) begin
            state       <= ST_IDLE;
            im_req      <= 1'b0;
            instruction <= im_rdata;
            ir_valid    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign im_addr    = pc;
  assign link       = pc;
  assign fetch_busy = (state == ST_WAIT) || IMen;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random cycles,
// all compared against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        IMen;
  logic        PCwr;
  logic [1:0]  NPCop;
  logic [31:0] rm_val;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic [31:0] instruction;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] link;
  logic        fetch_busy;

  int passed = 0;
  int total  = 0;
  int req_cycles;

  // Model: is a request outstanding, and the architecturally visible registers.
  bit          m_pending;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  bit          m_valid;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .IMen        (IMen),
    .PCwr        (PCwr),
    .NPCop       (NPCop),
    .rm_val      (rm_val),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_rdata    (im_rdata),
    .im_ack      (im_ack),
    .instruction (instruction),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .link        (link),
    .fetch_busy  (fetch_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_pc      = 32'h0;
    m_ir      = 32'h0;
    m_valid   = 0;
  endtask

  // One clock of the fetch rules, evaluated on the inputs present before the edge.
  task automatic model_step();
    int raw;
    int off;
    if (!m_pending) begin
      if (PCwr && NPCop == 2'd1) begin
        raw  = int'({m_ir[23:0], 8'h00});
        off  = raw >>> 8;
        m_pc = m_pc + 32'(4 + off * 4);
      end else if (PCwr && NPCop == 2'd2) begin
        m_pc = {rm_val[31:2], 2'b00};
      end
      if (IMen) begin
        m_pending = 1;
        m_valid   = 0;
      end
    end else if (im_ack) begin
      m_ir      = im_rdata;
      m_valid   = 1;
      m_pending = 0;
      if (PCwr && NPCop == 2'd0) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_comb();
    chk("im_req",     {31'b0, im_req},     {31'b0, m_pending});
    chk("im_addr",    im_addr,             m_pc);
    chk("link",       link,                m_pc);
    chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, (m_pending || IMen)});
  endtask

  task automatic check_regs();
    chk("pc",          pc,                m_pc);
    chk("instruction", instruction,       m_ir);
    chk("ir_valid",    {31'b0, ir_valid}, {31'b0, m_valid});
    chk("im_req_reg",  {31'b0, im_req},   {31'b0, m_pending});
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic tick();
    #3;
    check_comb();
    if (im_req) req_cycles++;
    model_step();
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic drive(input logic imen, input logic pcwr, input logic [1:0] op,
                       input logic [31:0] rm, input logic ack, input logic [31:0] rd);
    IMen     = imen;
    PCwr     = pcwr;
    NPCop    = op;
    rm_val   = rm;
    im_ack   = ack;
    im_rdata = rd;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 2'd0, 32'h0, 0, 32'h0);
    model_reset();
    #2;
    check_comb();
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Basic fetch with sequential PC advance on the ack cycle.
    drive(1, 0, 2'd0, 32'h0, 0, 32'h0);
    tick();
    chk("basic_im_addr", im_addr, 32'h0);
    drive(0, 1, 2'd0, 32'h0, 1, 32'hE280_1001);
    tick();
    chk("basic_ir", instruction, 32'hE280_1001);
    chk("basic_valid", {31'b0, ir_valid}, 32'd1);
    chk("basic_pc", pc, 32'h4);

    // Slow memory: five stall cycles then ack.
    req_cycles = 0;
    drive(1, 0, 2'd0, 32'h0, 0, 32'h0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 2'd0, 32'h0, 0, 32'h1234_5678);
      tick();
      chk("stall_addr", im_addr, 32'h4);
      chk("stall_pc", pc, 32'h4);
    end
    drive(0, 1, 2'd0, 32'h0, 1, 32'hAAAA_5555);
    tick();
    chk("stall_req_cycles", 32'(req_cycles), 32'd6);
    chk("stall_pc_after", pc, 32'h8);

    // Backward branch from 0x100 with imm -2.
    drive(0, 1, 2'd2, 32'h0000_0100, 0, 32'h0);
    tick();
    drive(1, 0, 2'd0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 2'd0, 32'h0, 1, 32'hEAFF_FFFE);
    tick();
    drive(0, 1, 2'd1, 32'h0, 0, 32'h0);
    #3;
    chk("branch_link_pre", link, 32'h0000_0100);
    #0;
    @(posedge clk);
    #1;
    model_step_after_manual();
    chk("branch_back_pc", pc, 32'h0000_00FC);

    // Forward branch wrapping past 2^32; register target low bits are masked.
    drive(0, 1, 2'd2, 32'hFFFF_FFFB, 0, 32'h0);
    tick();
    chk("reg_mask_pc", pc, 32'hFFFF_FFF8);
    drive(1, 0, 2'd0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 0, 2'd0, 32'h0, 1, 32'hEA00_0003);
    tick();
    drive(0, 1, 2'd1, 32'h0, 0, 32'h0);
    tick();
    chk("branch_wrap_pc", pc, 32'h0000_0008);

    // Register jump in IDLE is taken; the same request while waiting is not.
    drive(0, 1, 2'd2, 32'h0000_2003, 0, 32'h0);
    tick();
    chk("reg_jump_pc", pc, 32'h0000_2000);
    drive(1, 0, 2'd0, 32'h0, 0, 32'h0);
    tick();
    drive(0, 1, 2'd2, 32'h0000_5000, 0, 32'h0);
    tick();
    chk("reg_in_wait_pc", pc, 32'h0000_2000);
    drive(0, 1, 2'd3, 32'h0000_5000, 1, 32'h1111_2222);
    tick();
    chk("hold_pc", pc, 32'h0000_2000);

    // Back-to-back fetches with IMen held high across the ack.
    drive(1, 1, 2'd0, 32'h0, 0, 32'h0);
    tick();
    drive(1, 1, 2'd0, 32'h0, 1, 32'h3333_4444);
    tick();
    drive(1, 1, 2'd0, 32'h0, 0, 32'h0);
    tick();
    chk("b2b_req", {31'b0, im_req}, 32'd1);

    // Reset asserted mid-WAIT, then a late ack while idle.
    drive(0, 0, 2'd0, 32'h0, 0, 32'h0);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_im_req", {31'b0, im_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    #2;
    rst = 1'b1;
    drive(0, 0, 2'd0, 32'h0, 1, 32'hDEAD_BEEF);
    tick();
    chk("late_ack_valid", {31'b0, ir_valid}, 32'd0);
    chk("late_ack_ir", instruction, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            $urandom, ($urandom_range(0, 9) < 4), $urandom);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Model update for the one cycle clocked by hand around the pre-edge link probe.
  task automatic model_step_after_manual();
    model_step();
    check_regs();
  endtask

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port IMen, input, 1, fetch request from control FSM.
REQ-005 SHALL have port PCwr, input, 1, PC write enable from control FSM.
REQ-006 SHALL have port NPCop, input, 2, next-PC select: 00 PC+4, 01 branch target, 10 register target, 11 hold.
REQ-007 SHALL have port rm_val, input, 32, register operand for NPCop=10.
REQ-008 SHALL have ports im_req (output, 1), im_addr (output, 32), im_rdata (input, 32), im_ack (input, 1), instruction-memory handshake.
REQ-009 SHALL have port instruction, output, 32, instruction register (IR) to control and datapath.
REQ-010 SHALL have port ir_valid, output, 1, IR holds a completed fetch.
REQ-011 SHALL have port pc, output, 32, current PC register.
REQ-012 SHALL have port link, output, 32, return address for BL, equal to pc combinationally.
REQ-013 SHALL have port fetch_busy, output, 1, control must stall while high.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-015 IDLE with IMen=1 SHALL go to WAIT at next edge and clear ir_valid; IMen ignored in WAIT.
REQ-016 im_req SHALL be 1 exactly in WAIT; im_addr SHALL equal pc and stay stable throughout WAIT.
REQ-017 WAIT with im_ack=1 SHALL load IR from im_rdata, set ir_valid=1, return to IDLE at same edge.
REQ-018 WAIT with im_ack=0 SHALL hold state, im_addr and IR; no timeout.
REQ-019 im_ack in IDLE SHALL be ignored (no IR or ir_valid change).
REQ-020 fetch_busy SHALL equal (state==WAIT) OR (state==IDLE AND IMen), combinational.
REQ-021 Minimum latency IMen-to-IR-update SHALL be 2 cycles (IMen cycle, one WAIT cycle with ack).
REQ-022 PCwr with NPCop=00 SHALL be accepted only in the cycle WAIT and im_ack=1: pc <= pc+4.
REQ-023 PCwr with NPCop=01/10 SHALL be accepted only in IDLE; in WAIT it SHALL be ignored.
REQ-024 NPCop=01 target SHALL be pc + 4 + (sign-extended IR[23:0] << 2), modulo 2^32.
REQ-025 NPCop=10 target SHALL be rm_val with bits [1:0] forced to 0.
REQ-026 NPCop=11 or PCwr=0 SHALL leave pc unchanged.
REQ-027 After IMen deasserted and returned high in the ack cycle, the next fetch SHALL start on the following IDLE cycle (back-to-back, one IDLE cycle between requests).

Reset
REQ-028 rst low SHALL immediately force: state IDLE, im_req 0, pc RESET_PC, IR 0, ir_valid 0.
REQ-029 Reset during WAIT SHALL abandon the fetch; a late im_ack after release SHALL be ignored per REQ-019.
REQ-030 After rst rises, no fetch SHALL start until IMen is sampled high in IDLE.

Structure
REQ-031 Shared package SHALL hold NPCop encodings, FSM state encoding, RESET_PC default.
REQ-032 Next-PC mux and branch adder SHALL be one sub-module, npc_calc, combinational; FSM and registers stay in fetch_unit.

Verification
REQ-033 Reset then IMen=1, ack after 1 WAIT cycle, im_rdata=32'hE280_1001, PCwr/NPCop=00 -> im_addr=0, instruction=32'hE280_1001, ir_valid=1, pc=4.
REQ-034 ack delayed 5 cycles -> im_req high 5+1 cycles, im_addr constant, fetch_busy high throughout, IR/pc unchanged until ack cycle.
REQ-035 pc=0x100, IR[23:0]=24'hFFFFFE, PCwr, NPCop=01 in IDLE -> pc=0x100+4-8=0x0FC; link=0x100 before the edge.
REQ-036 IR[23:0]=24'h000003 at pc=0xFFFF_FFF8, NPCop=01 -> pc wraps to 0x0000_0008.
REQ-037 NPCop=10, rm_val=32'h0000_2003 -> pc=0x2000; same request during WAIT -> pc unchanged.
REQ-038 rst pulsed low mid-WAIT, then im_ack=1 in IDLE -> im_req 0 immediately, pc=RESET_PC, ir_valid stays 0.
